multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multi-cycle RV32I datapath around one shared ALU, one unified memory port, and the IR/OldPC/ALUOut/Data holding registers.
- Supported opcodes: R-type (add/sub/and/or/xor), I-type ALU, lw, sw, beq/bne, jal.
- Stretches memory-access states on a ready handshake, traps on illegal encodings, and pulses a retire strobe per completed instruction.

Parameters:
- DATA_WIDTH, 32, datapath width (informational; no output depends on it)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  7  opcode from IR
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR and OldPC enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J
- instr_retired  out  1  one-cycle pulse on final cycle of each instruction
- illegal  out  1  high while in TRAP

Behaviour:
- Clock and reset: one clock; rst synchronous, active-high, enters FETCH.
- While rst is high: PCWrite, IRWrite, RegWrite, MemWrite, instr_retired and illegal are forced 0.
- Defaults: every output not listed for a state is 0.
- ImmSrc is decoded from op in every state: I for 0010011/0000011, S for 0100011, B for 1100011, J for 1101111, else 000.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Else hold with both enables 0.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - R -> EXECR
  - I -> EXECI
  - branch -> BRANCH
  - jal -> JAL
  - any other op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_retired=1, go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held every cycle until mem_ready. On the mem_ready cycle: instr_retired=1, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00. ALUControl: funct3 000 gives add, or sub if funct7_5=1; 100 xor; 110 or; 111 and. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. Same funct3 map; funct7_5 ignored (addi never subtracts). Go to ALUWB.
- In EXECR/EXECI, any other funct3 -> TRAP with no register write.
- ALUWB: ResultSrc=00, RegWrite=1, instr_retired=1, go to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - funct3 000 (beq): PCWrite=zero.
  - funct3 001 (bne): PCWrite=~zero.
  - instr_retired=1, go to FETCH.
  - Any other funct3: PCWrite=0, go to TRAP.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 (target), PCWrite=1. Go to ALUWB, which writes PC+4 to rd.
- TRAP: illegal=1, all enables 0. Sticky until rst.
- Latency with mem_ready always 1 (no stalls): R/I/jal 4 cycles, lw 5, sw 4, branch 3.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- mem_ready is ignored in all other states.
- rst asserted in any state, including mid-stall or TRAP: next state is FETCH and no write enable is asserted in the reset cycle.

Test Plan:
- Reset then add (op 0110011, f3 000, f7_5 0), mem_ready=1 -> FETCH, DECODE, EXECR (ALUControl 0000), ALUWB with RegWrite=1; instr_retired on cycle 4; sub variant gives ALUControl 0001.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> IRWrite only on the ready cycle; MEMWB RegWrite=1 with ResultSrc=01; total 10 cycles.
- sw with mem_ready=0 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 consecutive cycles, AdrSrc=1, RegWrite never asserted.
- beq with zero=1, and bne with zero=1 -> PCWrite=1 and PCWrite=0 respectively in BRANCH; ALUControl 0001; 3 cycles each.
- jal -> JAL cycle with PCWrite=1 and ImmSrc=011, then ALUWB RegWrite=1; then op 0110111 -> illegal=1, held for 5 cycles until rst.
- rst pulse during a MEMWRITE stall -> MemWrite=0 in the reset cycle; next cycle FETCH with AdrSrc=0; illegal cleared.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for a multi-cycle RV32I datapath built around one shared ALU,
// one unified memory port and the IR/OldPC/ALUOut/Data holding registers.
// Supports R-type add/sub/and/or/xor, I-type ALU, lw, sw, beq/bne and jal.
// Memory-access states (FETCH, MEMREAD, MEMWRITE) stretch on mem_ready,
// illegal encodings park the FSM in a sticky TRAP state, and instr_retired
// pulses on the last cycle of every completed instruction.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset (enters FETCH)
//   op, funct3, funct7_5  instruction fields taken from IR
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite    datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc datapath mux/ALU controls
//   instr_retired         one-cycle pulse on the final cycle of an instruction
//   illegal               high while in TRAP
//
// The enables depend on mem_ready/zero/funct3 of the current cycle, so the
// output decode is a Mealy function of the state register rather than a set
// of flops; registering them would shift every enable one cycle late.
module multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       instr_retired,
  output logic       illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t state_r;

  logic       pc_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [3:0] alu_control_s;
  logic [2:0] imm_src_s;
  logic       retired_s;
  logic       illegal_s;

  // funct3 values with a defined ALU operation in EXECR/EXECI
  function automatic logic alu_f3_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100, 3'b110, 3'b111: alu_f3_legal = 1'b1;
      default:                        alu_f3_legal = 1'b0;
    endcase
  endfunction

  // funct3 -> ALU operation; sub_en selects sub for funct3 000 (R-type only)
  function automatic logic [3:0] alu_f3_decode(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_f3_decode = sub_en ? ALU_SUB : ALU_ADD;
      3'b100:  alu_f3_decode = ALU_XOR;
      3'b110:  alu_f3_decode = ALU_OR;
      3'b111:  alu_f3_decode = ALU_AND;
      default: alu_f3_decode = ALU_ADD;
    endcase
  endfunction

  // State register and next-state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH:    state_r <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state_r <= MEMADR;
            OP_R:         state_r <= EXECR;
            OP_I:         state_r <= EXECI;
            OP_BR:        state_r <= BRANCH;
            OP_JAL:       state_r <= JAL;
            default:      state_r <= TRAP;
          endcase
        end
        MEMADR:   state_r <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  state_r <= mem_ready ? MEMWB : MEMREAD;
        MEMWB:    state_r <= FETCH;
        MEMWRITE: state_r <= mem_ready ? FETCH : MEMWRITE;
        EXECR:    state_r <= alu_f3_legal(funct3) ? ALUWB : TRAP;
        EXECI:    state_r <= alu_f3_legal(funct3) ? ALUWB : TRAP;
        ALUWB:    state_r <= FETCH;
        BRANCH:   state_r <= (funct3 == 3'b000 || funct3 == 3'b001) ? FETCH : TRAP;
        JAL:      state_r <= ALUWB;
        TRAP:     state_r <= TRAP;
        default:  state_r <= FETCH;
      endcase
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_I, OP_LW: imm_src_s = 3'b000;
      OP_SW:       imm_src_s = 3'b001;
      OP_BR:       imm_src_s = 3'b010;
      OP_JAL:      imm_src_s = 3'b011;
      default:     imm_src_s = 3'b000;
    endcase
  end

  // Per-state control decode; anything not set for a state stays 0
  always_comb begin
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = 2'b00;
    alu_src_a_s   = 2'b00;
    alu_src_b_s   = 2'b00;
    alu_control_s = ALU_ADD;
    retired_s     = 1'b0;
    illegal_s     = 1'b0;
    case (state_r)
      FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_write_s   = mem_ready;
      end
      DECODE: begin
        // OldPC + imm precomputes the branch target into ALUOut
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      MEMREAD: begin
        adr_src_s = 1'b1;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        retired_s    = 1'b1;
      end
      MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        retired_s   = mem_ready;
      end
      EXECR: begin
        alu_src_a_s   = 2'b10;
        alu_control_s = alu_f3_decode(funct3, funct7_5);
      end
      EXECI: begin
        alu_src_a_s   = 2'b10;
        alu_src_b_s   = 2'b01;
        alu_control_s = alu_f3_decode(funct3, 1'b0);
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_s   = 2'b10;
        alu_control_s = ALU_SUB;
        if (funct3 == 3'b000) begin
          pc_write_s = zero;
          retired_s  = 1'b1;
        end else if (funct3 == 3'b001) begin
          pc_write_s = ~zero;
          retired_s  = 1'b1;
        end else begin
          pc_write_s = 1'b0;
          retired_s  = 1'b0;
        end
      end
      JAL: begin
        // ALUOut already holds the target from DECODE; ALU now forms PC+4
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      TRAP: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  // Reset masks every state-changing enable, even mid-stall or in TRAP
  assign PCWrite       = pc_write_s  & ~rst;
  assign IRWrite       = ir_write_s  & ~rst;
  assign RegWrite      = reg_write_s & ~rst;
  assign MemWrite      = mem_write_s & ~rst;
  assign instr_retired = retired_s   & ~rst;
  assign illegal       = illegal_s   & ~rst;
  assign AdrSrc        = adr_src_s;
  assign ResultSrc     = result_src_s;
  assign ALUSrcA       = alu_src_a_s;
  assign ALUSrcB       = alu_src_b_s;
  assign ALUControl    = alu_control_s;
  assign ImmSrc        = imm_src_s;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       instr_retired;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .instr_retired(instr_retired), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle of all outputs:
  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,retired,illegal}
  logic [19:0] obs_v;
  assign obs_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, instr_retired, illegal};

  function automatic logic [19:0] ev(
    input logic pcw, input logic adr, input logic mw, input logic irw, input logic rw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [3:0] alu, input logic [2:0] imm, input logic ret, input logic ill);
    ev = {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ret, ill};
  endfunction

  task automatic chk(input string tag, input logic [19:0] expv);
    #1;
    checks++;
    assert (obs_v === expv) else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, obs_v, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    tick();
    // reset cycle: FETCH muxes, all enables masked
    chk("reset", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    rst = 1'b0;

    // ---- add ----
    chk("add_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("add_decode", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("add_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("add_aluwb", ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b1,1'b0));
    tick();

    // ---- sub ----
    funct7_5 = 1'b1;
    chk("sub_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick(); tick();
    chk("sub_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0001,3'b000,1'b0,1'b0));
    tick();
    chk("sub_aluwb", ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b1,1'b0));
    tick();

    // ---- xor, or ----
    funct7_5 = 1'b0; funct3 = 3'b100;
    tick(); tick();
    chk("xor_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0100,3'b000,1'b0,1'b0));
    tick(); tick();
    funct3 = 3'b110;
    tick(); tick();
    chk("or_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0011,3'b000,1'b0,1'b0));
    tick(); tick();

    // ---- addi with funct7_5=1 still adds; andi ----
    op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick(); tick();
    chk("addi_execi", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,4'b0000,3'b000,1'b0,1'b0));
    tick(); tick();
    funct3 = 3'b111; funct7_5 = 1'b0;
    tick(); tick();
    chk("andi_execi", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,4'b0010,3'b000,1'b0,1'b0));
    tick();
    chk("andi_aluwb", ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b1,1'b0));
    tick();

    // ---- lw: 2 stalls in FETCH, 3 in MEMREAD -> 10 cycles ----
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
    chk("lw_fetch_stall1", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("lw_fetch_stall2", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick();
    mem_ready = 1'b1;
    chk("lw_fetch_ready", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick();
    mem_ready = 1'b0;  // ignored in DECODE/MEMADR
    chk("lw_decode", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("lw_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,4'b0000,3'b000,1'b0,1'b0));
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memread_stall", ev(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b0,1'b0));
      tick();
    end
    mem_ready = 1'b1;
    chk("lw_memread_ready", ev(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("lw_memwb", ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,4'b0000,3'b000,1'b1,1'b0));
    tick();

    // ---- sw: 2 stalls in MEMWRITE ----
    op = 7'b0100011;
    chk("sw_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b001,1'b0,1'b0));
    tick(); tick();
    chk("sw_memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,4'b0000,3'b001,1'b0,1'b0));
    tick();
    mem_ready = 1'b0;
    chk("sw_memwrite_stall1", ev(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b001,1'b0,1'b0));
    tick();
    chk("sw_memwrite_stall2", ev(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b001,1'b0,1'b0));
    tick();
    mem_ready = 1'b1;
    chk("sw_memwrite_ready", ev(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b001,1'b1,1'b0));
    tick();

    // ---- beq zero=1 taken, bne zero=1 not taken ----
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    chk("beq_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b010,1'b0,1'b0));
    tick(); tick();
    chk("beq_branch", ev(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0001,3'b010,1'b1,1'b0));
    tick();
    funct3 = 3'b001;
    chk("bne_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b010,1'b0,1'b0));
    tick(); tick();
    chk("bne_branch", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0001,3'b010,1'b1,1'b0));
    tick();

    // ---- jal ----
    op = 7'b1101111; zero = 1'b0;
    tick(); tick();
    chk("jal_jal", ev(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,4'b0000,3'b011,1'b0,1'b0));
    tick();
    chk("jal_aluwb", ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,3'b011,1'b1,1'b0));
    tick();

    // ---- lui is unsupported: sticky TRAP until rst ----
    op = 7'b0110111;
    tick();
    chk("lui_decode", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,4'b0000,3'b000,1'b0,1'b0));
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ready = i[0];
      chk("trap_hold", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b0,1'b1));
      tick();
    end
    rst = 1'b1; mem_ready = 1'b1;
    chk("trap_rst", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b0,1'b0));
    tick();
    rst = 1'b0; op = 7'b0110011; funct3 = 3'b001;
    chk("trap_exit_fetch", ev(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b000,1'b0,1'b0));
    tick(); tick();

    // ---- R-type with undefined funct3 traps, no register write ----
    chk("badf3_execr", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0000,3'b000,1'b0,1'b0));
    tick();
    chk("badf3_trap", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b000,1'b0,1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ---- rst during MEMWRITE stall ----
    op = 7'b0100011; funct3 = 3'b010;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    chk("swrst_stall", ev(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b001,1'b0,1'b0));
    rst = 1'b1;
    chk("swrst_rst_cycle", ev(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,3'b001,1'b0,1'b0));
    tick();
    rst = 1'b0;
    chk("swrst_fetch", ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,4'b0000,3'b001,1'b0,1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
